// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter that shares one combinational comparator
// among N_REQ requesters. One transaction takes three cycles (IDLE grant,
// COMPARE, RESP); the acknowledge pulse follows RESP by one registered cycle.
// Captured comparator flags are checked for internal consistency and any
// violation latches a sticky error.
//
// Handshake: a requester holds req high with stable req_a/req_b slices until
// it is granted (operands are sampled only at the grant edge). ack is a
// one-cycle, one-hot pulse that appears two cycles after the grant edge and
// marks flags as valid for that requester; a requester that still holds req
// during its ack cycle is arbitrated again as a fresh request.
module cmp_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  input  logic [5:0]             cmp_flags,
  output logic [N_REQ-1:0]       ack,
  output logic [5:0]             flags,
  output logic                   busy,
  output logic                   flag_err,
  output logic [1:0]             dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_next;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [N_REQ-1:0]   idx_onehot;
  logic               flags_bad;

  logic f_gt, f_ge, f_lt, f_le, f_eq, f_ne;

  assign {f_gt, f_ge, f_lt, f_le, f_eq, f_ne} = cmp_flags;

  // Round-robin search: first active request at or above ptr, wrapping.
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_a     = '0;
    pick_b     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = (int'(ptr) + k) % N_REQ;
      if (!pick_found && req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
        pick_a     = req_a[c*WIDTH +: WIDTH];
        pick_b     = req_b[c*WIDTH +: WIDTH];
      end
    end
  end

  // Decode of the granted index and the pointer that follows it.
  always_comb begin
    idx_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_onehot[k] = (int'(idx) == k);
    end
    if (int'(idx) == N_REQ - 1) ptr_next = '0;
    else                         ptr_next = idx + IW'(1);
  end

  // A consistent result has exactly one relation and agreeing derived flags.
  always_comb begin
    flags_bad = 1'b0;
    if (!({f_gt, f_lt, f_eq} == 3'b100 || {f_gt, f_lt, f_eq} == 3'b010 ||
          {f_gt, f_lt, f_eq} == 3'b001)) flags_bad = 1'b1;
    if (f_ge != (f_gt | f_eq)) flags_bad = 1'b1;
    if (f_le != (f_lt | f_eq)) flags_bad = 1'b1;
    if (f_ne == f_eq)          flags_bad = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: grant when idle, then compare, then respond.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (pick_found) state_next = S_COMPARE;
      S_COMPARE: state_next = S_RESP;
      S_RESP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Datapath registers: grant latch, flag capture, ack pulse, pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      ptr      <= '0;
      opa      <= '0;
      opb      <= '0;
      flags    <= '0;
      flag_err <= 1'b0;
      ack      <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            idx <= pick_idx;
            opa <= pick_a;
            opb <= pick_b;
          end
        end
        S_COMPARE: begin
          flags <= cmp_flags;
          if (flags_bad) flag_err <= 1'b1;
        end
        S_RESP: begin
          ack <= idx_onehot;
          ptr <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the operand latches.
  always_comb begin
    busy      = (state != S_IDLE);
    cmp_a     = opa;
    cmp_b     = opb;
    dbg_state = state;
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: randomized and directed stimulus for cmp_arbiter with a
// bench-side comparator, a round-robin reference model feeding an expected
// queue, and a monitor that pops and compares on every ack pulse.
module tb_cmp_arbiter;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int EW = N + 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [W-1:0]     cmp_a;
  logic [W-1:0]     cmp_b;
  logic [5:0]       cmp_flags;
  logic [N-1:0]     ack;
  logic [5:0]       flags;
  logic             busy;
  logic             flag_err;
  logic [1:0]       dbg_state;

  bit               inject;
  logic [W-1:0]     op_a [N];
  logic [W-1:0]     op_b [N];
  int               m_ptr;
  bit               m_err;

  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    m_e;
  int               n_checks;
  int               n_fail;

  cmp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_flags (cmp_flags),
    .ack       (ack),
    .flags     (flags),
    .busy      (busy),
    .flag_err  (flag_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparator and reference model ----------------
  function automatic logic [5:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a > b, a >= b, a < b, a <= b, a == b, a != b};
  endfunction

  always_comb cmp_flags = inject ? 6'b100000 : ref_flags(cmp_a, cmp_b);

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic model_serve(input int j);
    logic [5:0]   f;
    logic [N-1:0] oh;
    f = inject ? 6'b100000 : ref_flags(op_a[j], op_b[j]);
    if (inject) m_err = 1'b1;
    oh    = '0;
    oh[j] = 1'b1;
    exp_q.push_back({oh, f, m_err});
    m_ptr = (j + 1) % N;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack !== '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=%b with nothing expected", ack);
      end else begin
        m_e = exp_q.pop_front();
        check("ack", 32'(ack), 32'(m_e[EW-1 -: N]));
        check("flags", 32'(flags), 32'(m_e[6:1]));
        check("flag_err", 32'(flag_err), 32'(m_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'($urandom_range(0, 7));
      op_b[i] = W'($urandom_range(0, 7));
    end
  endtask

  // Raise mask; without hold each requester drops on its ack, with hold the
  // whole mask stays up for ntx transactions.
  task automatic run_batch(input logic [N-1:0] mask, input bit hold, input int ntx);
    logic [N-1:0] pend;
    int total;
    int got;
    int budget;
    int j;
    pend  = mask;
    total = 0;
    if (hold) begin
      for (int t = 0; t < ntx; t++) begin
        j = model_pick(mask);
        model_serve(j);
        total++;
      end
    end else begin
      while (pend != '0) begin
        j = model_pick(pend);
        model_serve(j);
        pend[j] = 1'b0;
        total++;
      end
    end
    @(negedge clk);
    drive_ops();
    req    = mask;
    got    = 0;
    budget = total * 3 + 10;
    while (got < total && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack != '0) begin
        got++;
        if (!hold) req = req & ~ack;
      end
      if (hold && got == total) req = '0;
    end
    if (got < total) begin
      n_checks++;
      n_fail++;
      $display("FAIL batch_timeout: got %0d acks expected %0d", got, total);
      exp_q.delete();
    end
    req = '0;
  endtask

  task automatic wait_ack_and_drop();
    int budget;
    budget = 10;
    while (ack == '0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (ack == '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected one within 10 cycles");
      exp_q.delete();
    end
    req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    inject   = 1'b0;
    m_ptr    = 0;
    m_err    = 1'b0;
    rst_n    = 1'b0;
    req      = '0;
    req_a    = '0;
    req_b    = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flag_err", 32'(flag_err), 0);
    check("rst_cmp_a", 32'(cmp_a), 0);
    check("rst_cmp_b", 32'(cmp_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request with detailed cycle timing: 5 vs 3.
    random_ops();
    op_a[0] = 3'd5;
    op_b[0] = 3'd3;
    model_serve(0);
    @(negedge clk);
    drive_ops();
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_compare", 32'(busy), 1);
    check("t1_ack_compare", 32'(ack), 0);
    check("t1_cmp_a", 32'(cmp_a), 5);
    check("t1_cmp_b", 32'(cmp_b), 3);
    @(negedge clk);
    check("t1_busy_resp", 32'(busy), 1);
    check("t1_ack_resp", 32'(ack), 0);
    check("t1_flags_early", 32'(flags), 32'(6'b110001));
    @(negedge clk);
    check("t1_ack", 32'(ack), 32'(4'b0001));
    check("t1_busy_ack", 32'(busy), 0);
    req = '0;
    @(negedge clk);
    check("t1_ack_width", 32'(ack), 0);
    check("t1_flag_err", 32'(flag_err), 0);

    // Equal operands on requester 2.
    random_ops();
    op_a[2] = 3'd4;
    op_b[2] = 3'd4;
    run_batch(4'b0100, 1'b0, 0);
    check("eq_flags", 32'(flags), 32'(6'b010110));

    // All four requesting continuously.
    random_ops();
    run_batch(4'b1111, 1'b1, 12);

    // Operand change after grant is ignored: 1 vs 6 latched, a0 becomes 7.
    random_ops();
    op_a[0] = 3'd1;
    op_b[0] = 3'd6;
    model_serve(0);
    @(negedge clk);
    drive_ops();
    req = 4'b0001;
    @(posedge clk);
    #1;
    req_a[2:0] = 3'd7;
    wait_ack_and_drop();
    check("late_change_flags", 32'(flags), 32'(6'b001101));

    // Inconsistent comparator result sets the sticky error.
    random_ops();
    inject = 1'b1;
    run_batch(4'b1000, 1'b0, 0);
    inject = 1'b0;
    check("fault_flag_err", 32'(flag_err), 1);
    for (int r = 0; r < 3; r++) begin
      random_ops();
      run_batch(4'($urandom_range(1, 15)), 1'b0, 0);
    end
    check("fault_sticky", 32'(flag_err), 1);

    // Reset during COMPARE aborts the transaction.
    random_ops();
    op_a[1] = 3'd6;
    op_b[1] = 3'd2;
    @(negedge clk);
    drive_ops();
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ack", 32'(ack), 0);
    check("abort_flags", 32'(flags), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_flag_err", 32'(flag_err), 0);
    check("abort_cmp_a", 32'(cmp_a), 0);
    check("abort_cmp_b", 32'(cmp_b), 0);
    check("abort_queue_empty", 32'(exp_q.size()), 0);
    req   = '0;
    m_ptr = 0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    random_ops();
    run_batch(4'b0010, 1'b0, 0);
    random_ops();
    run_batch(4'b1111, 1'b0, 0);

    // Randomized batches.
    for (int r = 0; r < 25; r++) begin
      random_ops();
      run_batch(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
